// File: rtl/game_sequencer.sv
// Run-time controller for the T-rex game: frame tick, animation timer, speed ramp, score and life cycle.
// Optional pause support is enabled by defining GAME_SEQ_PAUSE_EN.
module game_sequencer #(
  parameter int unsigned FRAME_DIV       = 833333,
  parameter int unsigned SPEED_INIT      = 6,
  parameter int unsigned SPEED_MAX       = 13,
  parameter int unsigned ACCEL_FRAMES    = 600,
  parameter int unsigned SCORE_FRAMES    = 6,
  parameter int unsigned RESTART_HOLDOFF = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_jump,
  input  logic        btn_duck,
`ifdef GAME_SEQ_PAUSE_EN
  input  logic        btn_pause,
`endif
  input  logic        collide,
  output logic        update,
  output logic [5:0]  timer,
  output logic [4:0]  speed,
  output logic        jump,
  output logic        duck,
  output logic        crash,
  output logic        trex_rst,
  output logic [16:0] score,
  output logic [1:0]  game_state
);

  localparam int unsigned DIV_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned ACC_W   = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam int unsigned SCR_W   = (SCORE_FRAMES > 1) ? $clog2(SCORE_FRAMES) : 1;
  localparam int unsigned HOLD_W  = (RESTART_HOLDOFF > 0) ? $clog2(RESTART_HOLDOFF + 1) : 1;
  localparam logic [16:0] SCORE_MAX = 17'd99999;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_PLAYING = 2'b01,
`ifdef GAME_SEQ_PAUSE_EN
    S_CRASHED = 2'b10,
    S_PAUSED  = 2'b11
`else
    S_CRASHED = 2'b10
`endif
  } state_t;

  state_t              state, state_n;
  logic [DIV_W-1:0]    div_cnt, div_n;
  logic                tick, tick_n;
  logic [5:0]          timer_n;
  logic [4:0]          speed_n;
  logic [16:0]         score_n;
  logic [ACC_W-1:0]    accel_cnt, accel_n;
  logic [SCR_W-1:0]    score_cnt, score_cnt_n;
  logic [HOLD_W-1:0]   holdoff, holdoff_n;
  logic                btn_prev;
  logic                trex_rst_n;
  logic                jump_edge;
`ifdef GAME_SEQ_PAUSE_EN
  logic                pause_prev;
  logic                pause_edge;
`endif

  // Frame tick is forced low while paused; the divider itself never stops.
`ifdef GAME_SEQ_PAUSE_EN
  assign update     = tick & (state != S_PAUSED);
  assign pause_edge = btn_pause & ~pause_prev;
`else
  assign update     = tick;
`endif
  assign jump_edge  = btn_jump & ~btn_prev;
  assign game_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      tick       <= 1'b0;
      timer      <= '0;
      speed      <= 5'(SPEED_INIT);
      score      <= '0;
      accel_cnt  <= '0;
      score_cnt  <= '0;
      holdoff    <= '0;
      btn_prev   <= 1'b0;
      trex_rst   <= 1'b0;
`ifdef GAME_SEQ_PAUSE_EN
      pause_prev <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      div_cnt    <= div_n;
      tick       <= tick_n;
      timer      <= timer_n;
      speed      <= speed_n;
      score      <= score_n;
      accel_cnt  <= accel_n;
      score_cnt  <= score_cnt_n;
      holdoff    <= holdoff_n;
      btn_prev   <= btn_jump;
      trex_rst   <= trex_rst_n;
`ifdef GAME_SEQ_PAUSE_EN
      pause_prev <= btn_pause;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    timer_n     = timer;
    speed_n     = speed;
    score_n     = score;
    accel_n     = accel_cnt;
    score_cnt_n = score_cnt;
    holdoff_n   = holdoff;
    trex_rst_n  = 1'b0;
    jump        = 1'b0;
    duck        = 1'b0;
    crash       = 1'b0;

    // Tick is registered so it lines up with the cycle the divider sits at its last count.
    div_n  = (div_cnt == DIV_W'(FRAME_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
    tick_n = (div_n == DIV_W'(FRAME_DIV - 1));

    if (update) begin
      timer_n = (timer == 6'd59) ? 6'd0 : timer + 6'd1;
    end

    case (state)
      S_IDLE: begin
        jump = btn_jump;
        if (update && btn_jump) begin
          state_n = S_PLAYING;
        end
      end
      S_PLAYING: begin
        jump  = btn_jump;
        duck  = btn_duck & ~btn_jump;
        crash = collide;
`ifdef GAME_SEQ_PAUSE_EN
        if (pause_edge) begin
          state_n = S_PAUSED;
        end else
`endif
        if (update) begin
          if (collide) begin
            state_n   = S_CRASHED;
            holdoff_n = '0;
          end else begin
            if (accel_cnt == ACC_W'(ACCEL_FRAMES - 1)) begin
              accel_n = '0;
              if (speed < 5'(SPEED_MAX)) begin
                speed_n = speed + 5'd1;
              end
            end else begin
              accel_n = accel_cnt + ACC_W'(1);
            end
            if (score_cnt == SCR_W'(SCORE_FRAMES - 1)) begin
              score_cnt_n = '0;
              if (score < SCORE_MAX) begin
                score_n = score + 17'd1;
              end
            end else begin
              score_cnt_n = score_cnt + SCR_W'(1);
            end
          end
        end
      end
      S_CRASHED: begin
        crash = 1'b1;
        // Restart outranks a coincident frame tick; only a fresh press qualifies.
        if (jump_edge && (holdoff == HOLD_W'(RESTART_HOLDOFF))) begin
          state_n     = S_PLAYING;
          trex_rst_n  = 1'b1;
          speed_n     = 5'(SPEED_INIT);
          score_n     = '0;
          accel_n     = '0;
          score_cnt_n = '0;
        end else if (update && (holdoff < HOLD_W'(RESTART_HOLDOFF))) begin
          holdoff_n = holdoff + HOLD_W'(1);
        end
      end
`ifdef GAME_SEQ_PAUSE_EN
      S_PAUSED: begin
        if (pause_edge) begin
          state_n = S_PLAYING;
        end
      end
`endif
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer with small frame/ramp parameters.
// Pause scenarios are exercised when GAME_SEQ_PAUSE_EN is defined.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_jump;
  logic        btn_duck;
  logic        collide;
`ifdef GAME_SEQ_PAUSE_EN
  logic        btn_pause;
`endif
  logic        update;
  logic [5:0]  timer;
  logic [4:0]  speed;
  logic        jump;
  logic        duck;
  logic        crash;
  logic        trex_rst;
  logic [16:0] score;
  logic [1:0]  game_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  game_sequencer #(
    .FRAME_DIV      (4),
    .SPEED_INIT     (6),
    .SPEED_MAX      (8),
    .ACCEL_FRAMES   (3),
    .SCORE_FRAMES   (2),
    .RESTART_HOLDOFF(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_jump  (btn_jump),
    .btn_duck  (btn_duck),
`ifdef GAME_SEQ_PAUSE_EN
    .btn_pause (btn_pause),
`endif
    .collide   (collide),
    .update    (update),
    .timer     (timer),
    .speed     (speed),
    .jump      (jump),
    .duck      (duck),
    .crash     (crash),
    .trex_rst  (trex_rst),
    .score     (score),
    .game_state(game_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_upd();
    int n = 0;
    while (!update && n < 16) begin
      step();
      n++;
    end
    chk("update_seen", 32'(update), 1);
  endtask

  task automatic frame();
    wait_upd();
    step();
  endtask

  initial begin
    rst = 1'b1; btn_jump = 1'b0; btn_duck = 1'b0; collide = 1'b0;
`ifdef GAME_SEQ_PAUSE_EN
    btn_pause = 1'b0;
`endif
    @(negedge clk);
    repeat (3) step();

    chk("rst_state",  32'(game_state), 0);
    chk("rst_update", 32'(update), 0);
    chk("rst_timer",  32'(timer), 0);
    chk("rst_speed",  32'(speed), 6);
    chk("rst_score",  32'(score), 0);
    chk("rst_trex",   32'(trex_rst), 0);
    chk("rst_jdc",    32'({jump, duck, crash}), 0);

    // Tick cadence: update high in the 4th, 8th, 12th cycle after release.
    rst = 1'b0;
    chk("tick_c1", 32'(update), 0);
    for (int k = 1; k <= 11; k++) begin
      step();
      chk($sformatf("tick_c%0d", k + 1), 32'(update), (k % 4 == 3) ? 1 : 0);
    end
    chk("tick_timer", 32'(timer), 2);
    chk("tick_state", 32'(game_state), 0);

    // Timer wrap after 60 updates.
    repeat (57) frame();
    chk("timer_59", 32'(timer), 59);
    frame();
    chk("timer_wrap", 32'(timer), 0);
    chk("idle_speed", 32'(speed), 6);
    chk("idle_state", 32'(game_state), 0);

    // Start and steer.
    btn_jump = 1'b1;
    #1;
    chk("idle_jump", 32'(jump), 1);
    wait_upd();
    chk("start_upd_state", 32'(game_state), 0);
    step();
    chk("start_state", 32'(game_state), 1);
    btn_duck = 1'b1;
    #1;
    chk("steer_both", 32'({jump, duck}), 2);
    btn_jump = 1'b0;
    #1;
    chk("steer_duck", 32'({jump, duck}), 1);
    btn_duck = 1'b0;

    // Speed and score ramp.
    repeat (3) frame();
    chk("ramp3_speed", 32'(speed), 7);
    chk("ramp3_score", 32'(score), 1);
    repeat (3) frame();
    chk("ramp6_speed", 32'(speed), 8);
    chk("ramp6_score", 32'(score), 3);
    repeat (4) frame();
    chk("ramp10_speed", 32'(speed), 8);
    chk("ramp10_score", 32'(score), 5);

    // Crash and holdoff.
    collide = 1'b1;
    #1;
    chk("play_crash", 32'(crash), 1);
    frame();
    collide = 1'b0;
    chk("crash_state", 32'(game_state), 2);
    btn_jump = 1'b1;
    #1;
    chk("crash_flags", 32'({jump, duck, crash}), 1);
    step();
    btn_jump = 1'b0;
    step();
    frame();
    btn_jump = 1'b1;
    step();
    chk("early_trex", 32'(trex_rst), 0);
    chk("early_state", 32'(game_state), 2);
    chk("crash_score", 32'(score), 5);
    btn_jump = 1'b0;
    step();
    frame();
    btn_jump = 1'b1;
    step();
    chk("restart_trex",  32'(trex_rst), 1);
    chk("restart_state", 32'(game_state), 1);
    chk("restart_score", 32'(score), 0);
    chk("restart_speed", 32'(speed), 6);
    step();
    chk("restart_pulse_end", 32'(trex_rst), 0);

    // Button held through the crash never restarts.
    collide = 1'b1;
    frame();
    collide = 1'b0;
    chk("held_crash", 32'(game_state), 2);
    for (int i = 0; i < 5; i++) begin
      frame();
      chk($sformatf("held_f%0d", i), 32'({game_state, trex_rst}), 4);
    end
    btn_jump = 1'b0;
    step();
    btn_jump = 1'b1;
    step();
    chk("held_restart_trex",  32'(trex_rst), 1);
    chk("held_restart_state", 32'(game_state), 1);
    btn_jump = 1'b0;

    // Reset in the middle of a game.
    repeat (2) frame();
    chk("mid_score", 32'(score), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_state", 32'(game_state), 0);
    chk("mid_rst_score", 32'(score), 0);
    chk("mid_rst_timer", 32'(timer), 0);
    chk("mid_rst_update", 32'(update), 0);

`ifdef GAME_SEQ_PAUSE_EN
    begin
      logic [5:0] t_frozen;
      int         upd_cnt;
      btn_jump = 1'b1;
      frame();
      btn_jump = 1'b0;
      chk("pause_play", 32'(game_state), 1);
      btn_pause = 1'b1;
      step();
      btn_pause = 1'b0;
      chk("paused_state", 32'(game_state), 3);
      t_frozen = timer;
      upd_cnt = 0;
      for (int i = 0; i < 40; i++) begin
        step();
        if (update) upd_cnt++;
      end
      chk("paused_updates", 32'(upd_cnt), 0);
      chk("paused_timer", 32'(timer), 32'(t_frozen));
      btn_pause = 1'b1;
      step();
      btn_pause = 1'b0;
      chk("resume_state", 32'(game_state), 1);
      wait_upd();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level run-time controller for the T-rex game. It derives the frame-update tick, the 0..59 animation timer and the speed ramp. It gates the player buttons into the character's jump/duck/crash inputs and sequences the IDLE -> PLAYING -> CRASHED -> restart life cycle, including score keeping. It sits between the input synchronisers and collision checker on one side and the trex character and horizon/obstacle blocks on the other.

## Interface
Parameters:
- FRAME_DIV, 833333: clk cycles per frame (50 MHz / 60).
- SPEED_INIT, 6: speed after reset/restart.
- SPEED_MAX, 13: speed saturation value (must be <= 31).
- ACCEL_FRAMES, 600: PLAYING frames per speed increment.
- SCORE_FRAMES, 6: PLAYING frames per score point.
- RESTART_HOLDOFF, 30: CRASHED frames before restart is accepted.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- btn_jump  in  1  synchronised jump button, level.
- btn_duck  in  1  synchronised duck button, level.
- collide  in  1  collision-checker result, combinational, level.
- update  out  1  one-cycle frame tick.
- timer  out  6  frame counter, 0..59.
- speed  out  5  current game speed.
- jump  out  1  to trex jump.
- duck  out  1  to trex duck.
- crash  out  1  to trex/horizon crash.
- trex_rst  out  1  one-cycle restart pulse to trex and obstacle blocks.
- score  out  17  binary score, 0..99999.
- game_state  out  2  00 IDLE, 01 PLAYING, 10 CRASHED.

## Operation
- Frame divider counts 0..FRAME_DIV-1 continuously in every state. update=1 in the cycle the count equals FRAME_DIV-1.
- timer increments on every update and wraps 59 -> 0.
- All state, speed, score and holdoff changes are registered and occur only on update cycles, except the restart transition.
- IDLE: jump = btn_jump, duck = 0, crash = 0. On update with btn_jump=1, go to PLAYING.
- PLAYING:
  - jump = btn_jump; duck = btn_duck & ~btn_jump (jump has priority).
  - crash = collide.
  - On update with collide=1, go to CRASHED and clear the holdoff counter.
  - Otherwise on update, advance the accel and score frame counters:
    - When the accel count reaches ACCEL_FRAMES-1, it wraps to 0 and speed += 1, saturating at SPEED_MAX.
    - When the score count reaches SCORE_FRAMES-1, it wraps to 0 and score += 1, saturating at 99999.
- CRASHED:
  - jump = 0, duck = 0, crash = 1.
  - Holdoff counter increments on update and saturates at RESTART_HOLDOFF.
  - Restart fires on a btn_jump rising edge (btn_jump=1 with the registered previous value 0) once holdoff == RESTART_HOLDOFF. The edge is detected on any clk cycle, not only update cycles.
  - On restart: trex_rst=1 for one cycle; next state PLAYING; speed = SPEED_INIT; score = 0; accel/score counters cleared; timer and frame divider untouched.
  - A button held through the crash never restarts; it must be released and pressed again.
- Collide in IDLE or CRASHED is ignored.
- The frame divider, timer, accel, score and holdoff counters are wide enough for their parameter ranges.
- Saturation is by compare, never by wrap.

## Timing
- Reset values: game_state=IDLE, update=0, timer=0, speed=SPEED_INIT, score=0, trex_rst=0, jump=duck=crash=0. The divider, all counters and the previous-button register are also 0.
- First update occurs FRAME_DIV cycles after rst deasserts.
- jump/duck/crash are combinational from state and the inputs, so trex samples consistent values in the update cycle itself.
- State change takes effect the cycle after update, which matches trex's registered next_state.
- trex_rst is asserted the cycle after the qualifying btn_jump edge, coincident with game_state becoming PLAYING.
- If restart coincides with update, restart wins: no holdoff or score action that cycle, and update is still emitted.
- rst mid-game: next cycle matches the reset values above regardless of state.

## Configuration
- GAME_SEQ_PAUSE_EN defined:
  - Adds input btn_pause (1 bit, synchronised level) and state PAUSED (game_state=11).
  - A btn_pause rising edge in PLAYING enters PAUSED; another edge leaves PAUSED back to PLAYING.
  - In PAUSED, update is forced to 0, timer/speed/score are frozen and jump=duck=crash=0. The frame divider keeps counting.
  - btn_pause edges in IDLE and CRASHED are ignored.
- GAME_SEQ_PAUSE_EN undefined: no btn_pause port and no PAUSED state; game_state value 11 never occurs.

## Test plan
- Reset and tick (FRAME_DIV=4): after rst release, update pulses at cycles 4, 8, 12. After 60 updates, timer reads 0 again. game_state=0 and speed=6 throughout.
- Start and steer: hold btn_jump across an update -> game_state=01 next cycle. In PLAYING, with btn_jump=btn_duck=1 -> jump=1 and duck=0; with btn_duck alone -> duck=1.
- Speed and score ramp (ACCEL_FRAMES=3, SCORE_FRAMES=2, SPEED_MAX=8): speed reaches 8 after 6 PLAYING updates and stays at 8. Score reads 5 after 10 PLAYING updates.
- Crash and holdoff (RESTART_HOLDOFF=2):
  - collide=1 on an update -> game_state=10 and crash=1; jump stays 0 even with btn_jump held.
  - A btn_jump edge after 1 CRASHED update -> no restart.
  - An edge after 2 CRASHED updates -> trex_rst pulse of 1 cycle, score=0, speed=6, game_state=01.
- Held button: btn_jump held high from before the crash through 5 CRASHED updates -> no trex_rst. Release then press -> trex_rst fires.
- Pause (GAME_SEQ_PAUSE_EN): a btn_pause pulse in PLAYING -> game_state=11, no update for 10 frames, timer frozen. A second pulse resumes PLAYING, and updates resume at the divider's next wrap.
